// File: rtl/write8to32_if.sv
// -----------------------------------------------------------------------------
// write8to32_if
// Bundles the transfer-control, byte-input and word-output handshake signals
// of the write8to32 byte-to-word packer.
//
//   base       byte address of the first word (signed, sampled on _start)
//   count      number of 32-bit words to assemble (signed, sampled on _start)
//   _start     capture base/count and begin a new transfer
//   _in0       incoming byte
//   _in_valid  producer has a byte on _in0
//   _in_ready  packer accepts a byte this cycle
//   _ready     consumer ready for the output tuple
//   _valid     output tuple valid
//   _done      last word of the transfer
//   _out0      word byte address (base + 4*i)
//   _out1      assembled little-endian word
//
// The master modport belongs to the side that starts transfers, supplies
// bytes and consumes words. The slave modport belongs to the packer.
// -----------------------------------------------------------------------------
interface write8to32_if;
    logic signed [31:0] base;
    logic signed [31:0] count;
    logic               _start;
    logic [7:0]         _in0;
    logic               _in_valid;
    logic               _in_ready;
    logic               _ready;
    logic               _valid;
    logic               _done;
    logic [31:0]        _out0;
    logic [31:0]        _out1;

    modport master (
        output base, count, _start, _in0, _in_valid, _ready,
        input  _in_ready, _valid, _done, _out0, _out1
    );

    modport slave (
        input  base, count, _start, _in0, _in_valid, _ready,
        output _in_ready, _valid, _done, _out0, _out1
    );
endinterface

// File: rtl/write8to32.sv
// -----------------------------------------------------------------------------
// write8to32
// Assembles a stream of bytes into 32-bit little-endian words. Each completed
// word is presented with its byte address (base + 4*i) and is held until the
// consumer takes it. A transfer of `count` words is started with _start.
//
//   _clock  single clock, all state changes on its rising edge
//   _reset  asynchronous, active-high reset
//   bus     write8to32_if.slave handshake bundle (see write8to32_if.sv)
// -----------------------------------------------------------------------------
module write8to32 (
    input  logic          _clock,
    input  logic          _reset,
    write8to32_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t      state_q,    state_d;
    logic [31:0] base_q,     base_d;
    logic [31:0] count_q,    count_d;
    logic [31:0] wordIdx_q,  wordIdx_d;
    logic [1:0]  byteIdx_q,  byteIdx_d;
    logic [31:0] word_q,     word_d;
    logic [31:0] out0_q,     out0_d;
    logic [31:0] out1_q,     out1_d;
    logic        valid_q,    valid_d;
    logic        done_q,     done_d;

    // Bytes are accepted only while collecting; this is combinational so the
    // producer sees it in the same cycle the state changes.
    assign bus._in_ready = (state_q == COLLECT);
    assign bus._valid    = valid_q;
    assign bus._done     = done_q;
    assign bus._out0     = out0_q;
    assign bus._out1     = out1_q;

    // State and data registers. Reset clears everything immediately, which
    // also throws away any partially assembled word.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            count_q   <= '0;
            wordIdx_q <= '0;
            byteIdx_q <= '0;
            word_q    <= '0;
            out0_q    <= '0;
            out1_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            count_q   <= count_d;
            wordIdx_q <= wordIdx_d;
            byteIdx_q <= byteIdx_d;
            word_q    <= word_d;
            out0_q    <= out0_d;
            out1_q    <= out1_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic. _start overrides whatever the FSM is doing, so a
    // restart in the middle of a word drops the bytes collected so far.
    // A non-positive count completes at once with _valid/_done and leaves
    // the previous address/word on the outputs.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        count_d   = count_q;
        wordIdx_d = wordIdx_q;
        byteIdx_d = byteIdx_q;
        word_d    = word_q;
        out0_d    = out0_q;
        out1_d    = out1_q;
        valid_d   = valid_q;
        done_d    = done_q;

        if (bus._start) begin
            base_d    = bus.base;
            count_d   = bus.count;
            wordIdx_d = '0;
            byteIdx_d = '0;
            word_d    = '0;
            valid_d   = 1'b0;
            done_d    = 1'b0;
            if (bus.count <= 32'sd0) begin
                valid_d = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = COLLECT;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_q && bus._ready) begin
                        valid_d = 1'b0;
                        done_d  = 1'b0;
                    end
                end
                COLLECT: begin
                    if (bus._in_valid) begin
                        word_d[{byteIdx_q, 3'b000} +: 8] = bus._in0;
                        byteIdx_d = byteIdx_q + 2'd1;
                        if (byteIdx_q == 2'd3) begin
                            out0_d  = base_q + {wordIdx_q[29:0], 2'b00};
                            out1_d  = word_d;
                            valid_d = 1'b1;
                            done_d  = (wordIdx_q == count_q - 32'd1);
                            word_d  = '0;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus._ready) begin
                        valid_d = 1'b0;
                        done_d  = 1'b0;
                        if (done_q) begin
                            state_d = IDLE;
                        end else begin
                            wordIdx_d = wordIdx_q + 32'd1;
                            state_d   = COLLECT;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write8to32.sv
// -----------------------------------------------------------------------------
// tb_write8to32
// Directed bench for write8to32: a table of per-cycle vectors for the basic
// two-word transfer and the zero-count case, followed by hand-written
// sequences for backpressure, gapped input, async reset with address wrap,
// and restart in the middle of a word.
// -----------------------------------------------------------------------------
module tb_write8to32;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    write8to32_if bus ();

    write8to32 dut (
        ._clock (clock),
        ._reset (reset),
        .bus    (bus.slave)
    );

    typedef struct {
        logic        start;
        logic [31:0] base;
        logic [31:0] count;
        logic        inValid;
        logic [7:0]  in0;
        logic        ready;
        logic        expInReady;
        logic        expValid;
        logic        expDone;
        logic [31:0] expOut0;
        logic [31:0] expOut1;
    } vec_t;

    vec_t vecs [15];
    logic [7:0] gapBytes [4];

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs at the falling edge, then let the rising
    // edge happen and step 1 time unit past it so outputs can be sampled.
    task automatic applyStimulus(input logic start, input logic [31:0] base,
                                 input logic [31:0] count, input logic inValid,
                                 input logic [7:0] in0, input logic ready);
        @(negedge clock);
        bus._start    = start;
        bus.base      = base;
        bus.count     = count;
        bus._in_valid = inValid;
        bus._in0      = in0;
        bus._ready    = ready;
        @(posedge clock);
        #1;
    endtask

    // Compare the full output tuple against the expected one.
    task automatic checkOutput(input string name, input logic expInReady,
                               input logic expValid, input logic expDone,
                               input logic [31:0] expOut0, input logic [31:0] expOut1);
        logic [66:0] act;
        logic [66:0] exp;
        act = {bus._in_ready, bus._valid, bus._done, bus._out0, bus._out1};
        exp = {expInReady, expValid, expDone, expOut0, expOut1};
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got in_ready=%b valid=%b done=%b out0=%h out1=%h, want in_ready=%b valid=%b done=%b out0=%h out1=%h",
                     name, act[66], act[65], act[64], act[63:32], act[31:0],
                     exp[66], exp[65], exp[64], exp[63:32], exp[31:0]);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // start base count inV in0 ready | inReady valid done out0 out1
        vecs[0]  = '{1'b1, 32'h100, 32'd2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0};
        vecs[1]  = '{1'b0, 32'h0,   32'd0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0};
        vecs[2]  = '{1'b0, 32'h0,   32'd0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0};
        vecs[3]  = '{1'b0, 32'h0,   32'd0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0};
        vecs[4]  = '{1'b0, 32'h0,   32'd0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h44332211};
        vecs[5]  = '{1'b0, 32'h0,   32'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h44332211};
        vecs[6]  = '{1'b0, 32'h0,   32'd0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h44332211};
        vecs[7]  = '{1'b0, 32'h0,   32'd0, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h44332211};
        vecs[8]  = '{1'b0, 32'h0,   32'd0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h44332211};
        vecs[9]  = '{1'b0, 32'h0,   32'd0, 1'b1, 8'h88, 1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 32'h88776655};
        vecs[10] = '{1'b0, 32'h0,   32'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h104, 32'h88776655};
        vecs[11] = '{1'b0, 32'h0,   32'd0, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 32'h104, 32'h88776655};
        vecs[12] = '{1'b1, 32'h200, 32'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h104, 32'h88776655};
        vecs[13] = '{1'b0, 32'h0,   32'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h104, 32'h88776655};
        vecs[14] = '{1'b0, 32'h0,   32'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h104, 32'h88776655};

        gapBytes[0] = 8'hAA;
        gapBytes[1] = 8'hBB;
        gapBytes[2] = 8'hCC;
        gapBytes[3] = 8'hDD;

        reset         = 1'b1;
        bus._start    = 1'b0;
        bus.base      = '0;
        bus.count     = '0;
        bus._in_valid = 1'b0;
        bus._in0      = '0;
        bus._ready    = 1'b0;

        #3;
        checkOutput("reset state", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].start, vecs[i].base, vecs[i].count,
                          vecs[i].inValid, vecs[i].in0, vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].expInReady, vecs[i].expValid,
                        vecs[i].expDone, vecs[i].expOut0, vecs[i].expOut1);
        end

        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'h300, 32'd1, 1'b0, 8'h00, 1'b0);
        checkOutput("bp start", 1'b1, 1'b0, 1'b0, 32'h104, 32'h88776655);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 32'h0, 32'd0, 1'b1, 8'(k + 1), 1'b0);
        end
        checkOutput("bp word", 1'b0, 1'b1, 1'b1, 32'h300, 32'h04030201);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'h0, 32'd0, 1'b1, 8'hEE, 1'b0);
            checkOutput($sformatf("bp hold%0d", k), 1'b0, 1'b1, 1'b1, 32'h300, 32'h04030201);
        end
        applyStimulus(1'b0, 32'h0, 32'd0, 1'b0, 8'h00, 1'b1);
        checkOutput("bp release", 1'b0, 1'b0, 1'b0, 32'h300, 32'h04030201);

        $display("[TB] gapped input");
        applyStimulus(1'b1, 32'h500, 32'd1, 1'b0, 8'h00, 1'b0);
        checkOutput("gap start", 1'b1, 1'b0, 1'b0, 32'h300, 32'h04030201);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 32'h0, 32'd0, 1'b1, gapBytes[k], 1'b0);
            if (k < 3) begin
                checkOutput($sformatf("gap byte%0d", k), 1'b1, 1'b0, 1'b0, 32'h300, 32'h04030201);
                applyStimulus(1'b0, 32'h0, 32'd0, 1'b0, 8'h55, 1'b0);
                checkOutput($sformatf("gap idle%0d", k), 1'b1, 1'b0, 1'b0, 32'h300, 32'h04030201);
            end
        end
        checkOutput("gap word", 1'b0, 1'b1, 1'b1, 32'h500, 32'hDDCCBBAA);
        applyStimulus(1'b0, 32'h0, 32'd0, 1'b0, 8'h00, 1'b1);
        checkOutput("gap release", 1'b0, 1'b0, 1'b0, 32'h500, 32'hDDCCBBAA);

        $display("[TB] async reset and address wrap");
        applyStimulus(1'b1, 32'h600, 32'd2, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'd0, 1'b1, 8'h01, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'd0, 1'b1, 8'h02, 1'b0);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'd0, 1'b1, 8'h77, 1'b0);
        checkOutput("post reset idle", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 32'hFFFFFFFC, 32'd2, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 32'h0, 32'd0, 1'b1, 8'(k + 1), 1'b1);
        end
        checkOutput("wrap word0", 1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h04030201);
        applyStimulus(1'b0, 32'h0, 32'd0, 1'b0, 8'h00, 1'b1);
        checkOutput("wrap handshake", 1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h04030201);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 32'h0, 32'd0, 1'b1, 8'(k + 5), 1'b1);
        end
        checkOutput("wrap word1", 1'b0, 1'b1, 1'b1, 32'h00000000, 32'h08070605);
        applyStimulus(1'b0, 32'h0, 32'd0, 1'b0, 8'h00, 1'b1);
        checkOutput("wrap release", 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h08070605);

        $display("[TB] restart mid-word");
        applyStimulus(1'b1, 32'h700, 32'd1, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'd0, 1'b1, 8'hA1, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'd0, 1'b1, 8'hA2, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'd0, 1'b1, 8'hA3, 1'b1);
        checkOutput("restart partial", 1'b1, 1'b0, 1'b0, 32'h0, 32'h08070605);
        applyStimulus(1'b1, 32'h800, 32'd1, 1'b1, 8'hA4, 1'b1);
        checkOutput("restart start", 1'b1, 1'b0, 1'b0, 32'h0, 32'h08070605);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 32'h0, 32'd0, 1'b1, 8'(8'hB1 + k), 1'b1);
        end
        checkOutput("restart word", 1'b0, 1'b1, 1'b1, 32'h800, 32'hB4B3B2B1);
        applyStimulus(1'b0, 32'h0, 32'd0, 1'b0, 8'h00, 1'b1);
        checkOutput("restart release", 1'b0, 1'b0, 1'b0, 32'h800, 32'hB4B3B2B1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
